// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: immediate formats, base-ISA opcodes and the decoded-result record for imm_gen_pipe.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // Sized for the widest XLEN; narrower builds use the low XLEN bits.
    localparam int XLEN_MAX = 64;

    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        imm_fmt_e            fmt;
        logic                illegal;
        logic [XLEN_MAX-1:0] target;
    } imm_res_t;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode: combinational immediate extraction, sign/zero extension and target add.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    output imm_res_t        res_o
);
    logic [6:0]      opc;
    logic [2:0]      f3;
    imm_fmt_e        fmt;
    logic            ill;
    logic [63:0]     imm64;
    logic [XLEN-1:0] imm_x;
    logic [XLEN-1:0] tgt;
    logic            rel;

    assign opc = inst_i[6:0];
    assign f3  = inst_i[14:12];

    always_comb begin
        fmt = FMT_NONE;
        ill = 1'b0;
        if (inst_i[1:0] != 2'b11) ill = 1'b1;
        else case (opc)
            OPC_LOAD, OPC_JALR: fmt = FMT_I;
            OPC_OPIMM:          fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SH : FMT_I;
            OPC_STORE:          fmt = FMT_S;
            OPC_BRANCH:         fmt = FMT_B;
            OPC_LUI, OPC_AUIPC: fmt = FMT_U;
            OPC_JAL:            fmt = FMT_J;
            OPC_SYSTEM:         fmt = (f3 != 3'b000) ? FMT_Z : FMT_NONE;
            OPC_OP, OPC_FENCE:  fmt = FMT_NONE;
            default:            ill = 1'b1;
        endcase
    end

    // Extend to 64 bits once; truncation to XLEN keeps the sign correct.
    always_comb begin
        case (fmt)
            FMT_I:   imm64 = {{52{inst_i[31]}}, inst_i[31:20]};
            FMT_SH:  imm64 = (XLEN == 64) ? {58'b0, inst_i[25:20]} : {59'b0, inst_i[24:20]};
            FMT_S:   imm64 = {{52{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            FMT_B:   imm64 = {{51{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            FMT_U:   imm64 = {{32{inst_i[31]}}, inst_i[31:12], 12'b0};
            FMT_J:   imm64 = {{43{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            FMT_Z:   imm64 = {59'b0, inst_i[19:15]};
            default: imm64 = '0;
        endcase
    end

    assign imm_x = imm64[XLEN-1:0];
    assign rel   = (fmt == FMT_B) || (fmt == FMT_J) || (fmt == FMT_U && opc == OPC_AUIPC);
    assign tgt   = pc_i + (rel ? imm_x : XLEN'(4));
    assign res_o = '{imm: imm64, fmt: fmt, illegal: ill, target: 64'(tgt)};

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator behind a 2-entry skid buffer.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output imm_fmt_e        out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_target
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    imm_res_t dec;
    imm_res_t main_q, main_d, skid_q, skid_d;
    logic     main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic     acc, drain;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst_i (in_inst),
        .pc_i   (in_pc),
        .res_o  (dec)
    );

    assign acc   = in_valid && !skid_v_q;
    assign drain = main_v_q && out_ready;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            if (drain) begin
                main_v_d = skid_v_q;
                main_d   = skid_v_q ? skid_q : main_q;
                skid_v_d = 1'b0;
            end
            // acc implies skid empty, so main is the target whenever it frees up this edge.
            if (acc && (!main_v_q || out_ready)) begin
                main_d   = dec;
                main_v_d = 1'b1;
            end else if (acc) begin
                skid_d   = dec;
                skid_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign in_ready    = !skid_v_q;
    assign out_valid   = main_v_q;
    assign out_imm     = XLEN'(main_q.imm);
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_target  = XLEN'(main_q.target);

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep against a FIFO reference model.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    typedef struct {
        longint unsigned imm;
        logic [2:0]      fmt;
        bit              ill;
        longint unsigned tgt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        ir32, ov32, il32, ir64, ov64, il64;
    logic [31:0] imm32, tg32;
    logic [63:0] imm64, tg64;
    imm_fmt_e    fm32, fm64;
    exp_t        q32[$], q64[$];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(ov32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fm32), .out_illegal(il32), .out_target(tg32)
    );

    imm_gen_pipe #(.XLEN(64)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fm64), .out_illegal(il64), .out_target(tg64)
    );

    function automatic longint unsigned sx(longint unsigned v, int b);
        longint signed t = longint'(v << (64 - b));
        return longint'(t >>> (64 - b));
    endfunction

    function automatic exp_t ref_model(bit [31:0] inst, longint unsigned pc, int xl);
        exp_t r;
        longint unsigned mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        int opc = int'(inst & 32'h7F);
        int f3  = int'((inst >> 12) & 7);
        bit rel;
        r = '{imm: 0, fmt: FMT_NONE, ill: 1'b0, tgt: 0};
        if ((inst & 3) != 3) r.ill = 1'b1;
        else if (opc == 'h03 || opc == 'h67 || (opc == 'h13 && f3 != 1 && f3 != 5)) begin
            r.fmt = FMT_I; r.imm = sx(inst >> 20, 12);
        end else if (opc == 'h13) begin
            r.fmt = FMT_SH; r.imm = (inst >> 20) & ((xl == 64) ? 63 : 31);
        end else if (opc == 'h23) begin
            r.fmt = FMT_S; r.imm = sx(((inst >> 25) << 5) | ((inst >> 7) & 31), 12);
        end else if (opc == 'h63) begin
            r.fmt = FMT_B;
            r.imm = sx((((inst >> 31) & 1) << 12) | (((inst >> 7) & 1) << 11) |
                       (((inst >> 25) & 63) << 5) | (((inst >> 8) & 15) << 1), 13);
        end else if (opc == 'h37 || opc == 'h17) begin
            r.fmt = FMT_U; r.imm = sx(inst & 32'hFFFF_F000, 32);
        end else if (opc == 'h6F) begin
            r.fmt = FMT_J;
            r.imm = sx((((inst >> 31) & 1) << 20) | (((inst >> 12) & 255) << 12) |
                       (((inst >> 20) & 1) << 11) | (((inst >> 21) & 1023) << 1), 21);
        end else if (opc == 'h73 && f3 != 0) begin
            r.fmt = FMT_Z; r.imm = (inst >> 15) & 31;
        end else if (!(opc == 'h33 || opc == 'h0F || opc == 'h73)) r.ill = 1'b1;
        r.imm = r.imm & mask;
        rel   = (r.fmt == FMT_B) || (r.fmt == FMT_J) || opc == 'h17;
        r.tgt = (pc + (rel ? r.imm : 4)) & mask;
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid32", 64'(ov32), 64'(q32.size() > 0));
        chk("valid64", 64'(ov64), 64'(q64.size() > 0));
        chk("ready32", 64'(ir32), 64'(q32.size() < 2));
        chk("ready64", 64'(ir64), 64'(q64.size() < 2));
        if (q32.size() > 0) begin
            chk("imm32", 64'(imm32), q32[0].imm);
            chk("fmt32", 64'(fm32), 64'(q32[0].fmt));
            chk("ill32", 64'(il32), 64'(q32[0].ill));
            chk("tgt32", 64'(tg32), q32[0].tgt);
            chk("imm64", imm64, q64[0].imm);
            chk("fmt64", 64'(fm64), 64'(q64[0].fmt));
            chk("ill64", 64'(il64), 64'(q64[0].ill));
            chk("tgt64", tg64, q64[0].tgt);
        end
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_valid"}, 64'({ov32, ov64}), 64'(0));
        chk({tag, "_ready"}, 64'({ir32, ir64}), 64'(3));
        chk({tag, "_imm"}, imm64 | 64'(imm32), 64'(0));
        chk({tag, "_tgt"}, tg64 | 64'(tg32), 64'(0));
        chk({tag, "_fmt_ill"}, 64'({fm32, fm64, il32, il64}), 64'(0));
    endtask

    task automatic cyc();
        bit acc, drn;
        @(negedge clk);
        check_all();
        acc = in_valid && q32.size() < 2;
        drn = out_ready && q32.size() > 0;
        @(posedge clk);
        if (flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (drn) begin
                void'(q32.pop_front());
                void'(q64.pop_front());
            end
            if (acc) begin
                q32.push_back(ref_model(in_inst, in_pc, 32));
                q64.push_back(ref_model(in_inst, in_pc, 64));
            end
        end
        #1;
    endtask

    // Single accepted instruction into an empty stage, then fixed expected values.
    task automatic vec(string tag, logic [31:0] inst, logic [63:0] pc,
                       logic [63:0] e_imm64, logic [2:0] e_fmt, logic e_ill, logic [63:0] e_tgt64);
        in_inst = inst; in_pc = pc; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk({tag, "_imm32"}, 64'(imm32), 64'(e_imm64[31:0]));
        chk({tag, "_imm64"}, imm64, e_imm64);
        chk({tag, "_fmt"}, 64'({fm32, fm64}), 64'({e_fmt, e_fmt}));
        chk({tag, "_ill"}, 64'({il32, il64}), 64'({e_ill, e_ill}));
        chk({tag, "_tgt32"}, 64'(tg32), 64'(e_tgt64[31:0]));
        cyc();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] opcs [14] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                                  7'h6F, 7'h73, 7'h33, 7'h0F, 7'h7F, 7'h13, 7'h63};
        logic [31:0] w = $urandom;
        if ($urandom_range(9) != 0) w[6:0] = opcs[$urandom_range(13)];
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = '0; in_pc = '0;
        #1;
        chk_reset("reset");
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        vec("addi", 32'hFFF0_0093, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0, 64'h104);
        vec("beq",  32'hFE00_0EE3, 64'h200, 64'hFFFF_FFFF_FFFF_FFFC, FMT_B, 1'b0, 64'h1FC);
        vec("jal",  32'h0080_00EF, 64'h1000, 64'h8, FMT_J, 1'b0, 64'h1008);
        vec("lui",  32'h8000_00B7, 64'h0, 64'hFFFF_FFFF_8000_0000, FMT_U, 1'b0, 64'h4);
        vec("auipc", 32'h1234_5097, 64'h10, 64'h1234_5000, FMT_U, 1'b0, 64'h1234_5010);
        vec("csr",  32'h340F_1073, 64'h20, 64'd30, FMT_Z, 1'b0, 64'h24);
        vec("zero", 32'h0000_0000, 64'h40, 64'h0, FMT_NONE, 1'b1, 64'h44);
        vec("add",  32'h0000_0033, 64'h80, 64'h0, FMT_NONE, 1'b0, 64'h84);
        in_inst = 32'h43F0_D093; in_pc = 64'h300; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("srai_imm64", imm64, 64'd63);
        chk("srai_imm32", 64'(imm32), 64'd31);
        chk("srai_fmt", 64'(fm64), 64'(FMT_SH));
        cyc();

        // Backpressure: A in main, B in skid, C stalled, then ordered drain.
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'h0010_0013; cyc();
        in_inst = 32'h0020_0013; cyc();
        chk("bp_ready_low", 64'({ir32, ir64}), 64'(0));
        in_inst = 32'h0030_0013; cyc(); cyc();
        chk("bp_hold_a", 64'(imm32), 64'd1);
        chk("bp_stall", 64'({ir32, ir64}), 64'(0));
        out_ready = 1'b1; cyc();
        chk("bp_b", 64'(imm32), 64'd2);
        cyc();
        in_valid = 1'b0;
        chk("bp_c", 64'(imm64), 64'd3);
        cyc();
        chk("bp_empty", 64'({ov32, ov64}), 64'(0));

        // Flush with both entries full and input pending, then with in_ready high.
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'h0050_0013; cyc();
        in_inst = 32'h0060_0013; cyc();
        flush = 1'b1; cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 64'({ov32, ov64}), 64'(0));
        chk("flush_ready", 64'({ir32, ir64}), 64'(3));
        in_valid = 1'b1; in_inst = 32'h0070_0013; cyc();
        in_inst = 32'h0080_0013; flush = 1'b1; cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
        chk("flush_nostale", 64'({ov32, ov64}), 64'(0));

        for (int i = 0; i < 400; i++) begin
            in_valid  = $urandom_range(3) != 0;
            out_ready = $urandom_range(2) != 0;
            flush     = $urandom_range(24) == 0;
            in_inst   = rand_inst();
            in_pc     = {$urandom, $urandom};
            cyc();
        end

        // Asynchronous reset in the middle of traffic.
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'hFFF0_0093; cyc();
        in_inst = 32'h0080_00EF; cyc();
        #2 rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        q32.delete(); q64.delete();
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
